// File: rtl/frame_stream_gen.sv
`default_nettype none
// ============================================================================
//  Module      : frame_stream_gen
//  Description : Reads a stored frame from a synchronous-read frame buffer and
//                replays it as a timed raster (vsync/hsync/de/data). Vertical
//                timing is sync lines, back-porch lines, then V_RES active
//                lines. Each active line waits for i_ready before it starts.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_stream_gen #(
    parameter int WIDTH   = 8,
    parameter int H_RES   = 170,
    parameter int V_RES   = 240,
    parameter int H_BLANK = 8,
    parameter int H_SYNC  = 2,
    parameter int V_SYNC  = 1,
    parameter int V_BACK  = 2
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           i_start,
    input  logic                           i_continuous,
    input  logic                           i_ready,
    output logic                           o_rd_en,
    output logic [$clog2(H_RES*V_RES)-1:0] o_rd_addr,
    input  logic [WIDTH-1:0]               i_rd_data,
    output logic                           o_vsync,
    output logic                           o_hsync,
    output logic                           o_de,
    output logic [WIDTH-1:0]               o_data,
    output logic                           o_busy,
    output logic                           o_frame_done
);

    localparam int c_H_TOT = H_RES + H_BLANK;
    localparam int c_HW    = $clog2(c_H_TOT);
    localparam int c_AW    = $clog2(H_RES * V_RES);
    localparam int c_VMAX  = (V_RES > V_SYNC) ? ((V_RES > V_BACK) ? V_RES : V_BACK)
                                              : ((V_SYNC > V_BACK) ? V_SYNC : V_BACK);
    localparam int c_VW    = $clog2(c_VMAX + 1);

    localparam logic [c_HW-1:0] c_H_LAST      = c_HW'(c_H_TOT - 1);
    localparam logic [c_HW-1:0] c_H_ACT       = c_HW'(H_RES);
    localparam logic [c_HW-1:0] c_H_SYNC_LAST = c_HW'(H_RES + H_SYNC - 1);
    localparam logic [c_VW-1:0] c_V_SYNC_LAST = c_VW'(V_SYNC - 1);
    localparam logic [c_VW-1:0] c_V_BACK_LAST = c_VW'((V_BACK > 0) ? V_BACK - 1 : 0);
    localparam logic [c_VW-1:0] c_V_RES_LAST  = c_VW'(V_RES - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_VSYNC    = 3'd1;
    localparam logic [2:0] S_VBACK    = 3'd2;
    localparam logic [2:0] S_WAIT_RDY = 3'd3;
    localparam logic [2:0] S_ACTIVE   = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    logic [2:0]      r_state;
    logic [2:0]      r_state_next;
    logic [c_HW-1:0] r_h_cnt;
    logic [c_VW-1:0] r_v_cnt;
    logic [c_AW-1:0] r_addr;
    logic            r_rd_en_d;
    logic [2:0]      r_de_pipe;
    logic [2:0]      r_hs_pipe;
    logic [2:0]      r_vs_pipe;

    logic w_line_end;
    logic w_hs_win;
    logic w_pix;
    logic w_hs_int;
    logic w_vs_int;

    assign w_line_end = (r_h_cnt == c_H_LAST);
    assign w_hs_win   = (r_h_cnt >= c_H_ACT) && (r_h_cnt <= c_H_SYNC_LAST);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= r_state_next;
        end
    end

    // Next-state logic; a start request is only seen from IDLE
    always_comb begin
        r_state_next = r_state;
        case (r_state)
            S_IDLE:     if (i_start) r_state_next = S_VSYNC;
            S_VSYNC:    if (w_line_end && (r_v_cnt == c_V_SYNC_LAST))
                            r_state_next = (V_BACK == 0) ? S_WAIT_RDY : S_VBACK;
            S_VBACK:    if (w_line_end && (r_v_cnt == c_V_BACK_LAST))
                            r_state_next = S_WAIT_RDY;
            S_WAIT_RDY: if (i_ready) r_state_next = S_ACTIVE;
            S_ACTIVE:   if (w_line_end)
                            r_state_next = (r_v_cnt == c_V_RES_LAST) ? S_DONE : S_WAIT_RDY;
            S_DONE:     r_state_next = i_continuous ? S_VSYNC : S_IDLE;
            default:    r_state_next = S_IDLE;
        endcase
    end

    // Undelayed raster signals and status outputs decoded from the state
    always_comb begin
        w_pix        = 1'b0;
        w_hs_int     = 1'b0;
        w_vs_int     = 1'b0;
        o_busy       = (r_state != S_IDLE);
        o_frame_done = (r_state == S_DONE);
        case (r_state)
            S_VSYNC: begin
                w_vs_int = 1'b1;
                w_hs_int = w_hs_win;
            end
            S_VBACK:  w_hs_int = w_hs_win;
            S_ACTIVE: begin
                w_pix    = (r_h_cnt < c_H_ACT);
                w_hs_int = w_hs_win;
            end
            default: ;
        endcase
    end

    // Pixel, line and address counters; v_cnt restarts whenever its state is left
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
            r_addr  <= '0;
        end else begin
            case (r_state)
                S_VSYNC, S_VBACK, S_ACTIVE: r_h_cnt <= w_line_end ? '0 : r_h_cnt + c_HW'(1);
                default:                    r_h_cnt <= '0;
            endcase
            case (r_state)
                S_VSYNC, S_VBACK: if (w_line_end)
                    r_v_cnt <= (r_state_next == r_state) ? r_v_cnt + c_VW'(1) : '0;
                S_ACTIVE: if (w_line_end)
                    r_v_cnt <= (r_state_next == S_DONE) ? '0 : r_v_cnt + c_VW'(1);
                S_WAIT_RDY: r_v_cnt <= r_v_cnt;
                default:    r_v_cnt <= '0;
            endcase
            if (r_state == S_DONE) begin
                r_addr <= '0;
            end else if (w_pix) begin
                r_addr <= r_addr + c_AW'(1);
            end
        end
    end

    // Read port plus three-stage sync delay so o_de lines up with the returned pixel
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_rd_en   <= 1'b0;
            o_rd_addr <= '0;
            r_rd_en_d <= 1'b0;
            o_data    <= '0;
            r_de_pipe <= '0;
            r_hs_pipe <= '0;
            r_vs_pipe <= '0;
        end else begin
            o_rd_en   <= w_pix;
            o_rd_addr <= r_addr;
            r_rd_en_d <= o_rd_en;
            if (r_rd_en_d) begin
                o_data <= i_rd_data;
            end
            r_de_pipe <= {r_de_pipe[1:0], w_pix};
            r_hs_pipe <= {r_hs_pipe[1:0], w_hs_int};
            r_vs_pipe <= {r_vs_pipe[1:0], w_vs_int};
        end
    end

    assign o_de    = r_de_pipe[2];
    assign o_hsync = r_hs_pipe[2];
    assign o_vsync = r_vs_pipe[2];

endmodule
`default_nettype wire

// File: tb/tb_frame_stream_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_stream_gen
//  Description : Scoreboard bench for frame_stream_gen on a 4x3 frame whose
//                buffer holds data == address.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_stream_gen;

    localparam int WIDTH   = 8;
    localparam int H_RES   = 4;
    localparam int V_RES   = 3;
    localparam int H_BLANK = 3;
    localparam int H_SYNC  = 1;
    localparam int V_SYNC  = 1;
    localparam int V_BACK  = 1;
    localparam int AW      = $clog2(H_RES * V_RES);
    localparam int FRAME_LEN = 39;   // start cycle -> DONE cycle

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             i_start = 1'b0;
    logic             i_continuous = 1'b0;
    logic             i_ready = 1'b1;
    logic             o_rd_en;
    logic [AW-1:0]    o_rd_addr;
    logic [WIDTH-1:0] i_rd_data;
    logic             o_vsync, o_hsync, o_de, o_busy, o_frame_done;
    logic [WIDTH-1:0] o_data;

    frame_stream_gen #(
        .WIDTH(WIDTH), .H_RES(H_RES), .V_RES(V_RES), .H_BLANK(H_BLANK),
        .H_SYNC(H_SYNC), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
    ) dut (
        .clk(clk), .rstn(rstn), .i_start(i_start), .i_continuous(i_continuous),
        .i_ready(i_ready), .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr),
        .i_rd_data(i_rd_data), .o_vsync(o_vsync), .o_hsync(o_hsync),
        .o_de(o_de), .o_data(o_data), .o_busy(o_busy), .o_frame_done(o_frame_done)
    );

    always #5 clk = ~clk;

    // Frame buffer model: synchronous read, content equals address
    always @(posedge clk) if (o_rd_en) i_rd_data <= WIDTH'(o_rd_addr);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard and monitor state
    int         exp_q[$];
    int         de_cyc[$];
    int         de_cnt = 0, vs_cnt = 0, hs_rise = 0, fd_cnt = 0, fd_cyc = 0;
    logic       hs_prev = 1'b0;
    logic [1:0] rd_hist = 2'b00;

    // Monitor: pops expected pixels on o_de and tallies raster events
    always @(negedge clk) begin
        if (!rstn) begin
            rd_hist = 2'b00;
            hs_prev = 1'b0;
        end else begin
            if (o_de) begin
                de_cnt++;
                de_cyc.push_back(cyc);
                if (exp_q.size() == 0) check("unexpected_de", 1, 0);
                else                   check("pixel", int'(o_data), exp_q.pop_front());
                check("de_during_vsync", int'(o_vsync), 0);
            end
            if (o_de || rd_hist[1]) check("rd_to_de_offset", int'(o_de), int'(rd_hist[1]));
            rd_hist = {rd_hist[0], o_rd_en};
            if (o_vsync) vs_cnt++;
            if (o_hsync && !hs_prev) hs_rise++;
            hs_prev = o_hsync;
            if (o_frame_done) begin
                fd_cnt++;
                fd_cyc = cyc;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_frame();
        for (int i = 0; i < H_RES * V_RES; i++) exp_q.push_back(i);
    endtask

    task automatic pulse_start(output int s);
        i_start = 1'b1;
        s = cyc;
        step();
        i_start = 1'b0;
    endtask

    task automatic wait_fd(input int target, input string name);
        for (int k = 0; k < 300 && fd_cnt < target; k++) step();
        check(name, fd_cnt, target);
    endtask

    task automatic wait_addr(input int a, input string name);
        for (int k = 0; k < 100 && !(o_rd_en && int'(o_rd_addr) == a); k++) step();
        check(name, int'(o_rd_en && int'(o_rd_addr) == a), 1);
    endtask

    function automatic int gap(input int i);
        if (de_cyc.size() > i + 1) return de_cyc[i+1] - de_cyc[i];
        return -1;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd_en"}, int'(o_rd_en), 0);
        check({tag, "_rd_addr"}, int'(o_rd_addr), 0);
        check({tag, "_de"}, int'(o_de), 0);
        check({tag, "_vsync"}, int'(o_vsync), 0);
        check({tag, "_hsync"}, int'(o_hsync), 0);
        check({tag, "_data"}, int'(o_data), 0);
        check({tag, "_busy"}, int'(o_busy), 0);
        check({tag, "_frame_done"}, int'(o_frame_done), 0);
    endtask

    int s, b_de, b_vs, b_hs, b_fd, b_dq;

    task automatic snap();
        b_de = de_cnt; b_vs = vs_cnt; b_hs = hs_rise; b_fd = fd_cnt; b_dq = de_cyc.size();
    endtask

    task automatic check_frame(input string tag, input int nf);
        check({tag, "_de_count"}, de_cnt - b_de, 12 * nf);
        check({tag, "_vsync_cycles"}, vs_cnt - b_vs, 7 * nf);
        check({tag, "_hsync_pulses"}, hs_rise - b_hs, 5 * nf);
        check({tag, "_frame_done"}, fd_cnt - b_fd, nf);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        check({tag, "_busy_end"}, int'(o_busy), 0);
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        check_outputs_zero("reset");
        rstn = 1'b1;
        repeat (2) step();
        check("idle_busy", int'(o_busy), 0);

        // Single frame, downstream always ready
        snap(); push_frame(); pulse_start(s);
        check("t1_busy_after_start", int'(o_busy), 1);
        wait_fd(b_fd + 1, "t1_done_seen");
        check("t1_frame_len", fd_cyc - s, FRAME_LEN);
        step();
        check("t1_busy_clear", int'(o_busy), 0);
        repeat (5) step();
        check_frame("t1", 1);
        check("t1_gap_l1_l2", gap(b_dq + 3), 5);
        check("t1_gap_in_line", gap(b_dq + 4), 1);

        // i_ready low for 10 extra wait cycles ahead of line 2
        snap(); push_frame(); pulse_start(s);
        wait_addr(3, "t2_saw_addr3");
        i_ready = 1'b0;
        repeat (13) step();
        i_ready = 1'b1;
        wait_fd(b_fd + 1, "t2_done_seen");
        check("t2_frame_len", fd_cyc - s, FRAME_LEN + 10);
        repeat (6) step();
        check_frame("t2", 1);
        check("t2_gap_stall", gap(b_dq + 3), 15);
        check("t2_line2_contig", gap(b_dq + 4) + gap(b_dq + 5) + gap(b_dq + 6), 3);
        check("t2_gap_l2_l3", gap(b_dq + 7), 5);

        // Continuous replay: two back-to-back frames
        snap(); push_frame(); push_frame(); i_continuous = 1'b1; pulse_start(s);
        wait_fd(b_fd + 1, "t3_first_done");
        check("t3_first_len", fd_cyc - s, FRAME_LEN);
        step();
        check("t3_busy_between", int'(o_busy), 1);
        step();
        i_continuous = 1'b0;
        wait_fd(b_fd + 2, "t3_second_done");
        check("t3_second_len", fd_cyc - s, 2 * FRAME_LEN);
        repeat (6) step();
        check_frame("t3", 2);

        // Start request mid-frame is ignored
        snap(); push_frame(); pulse_start(s);
        repeat (20) step();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        wait_fd(b_fd + 1, "t4_done_seen");
        check("t4_frame_len", fd_cyc - s, FRAME_LEN);
        repeat (50) step();
        check_frame("t4", 1);

        // Asynchronous reset during the second active line, then a clean frame
        snap(); push_frame(); pulse_start(s);
        wait_addr(5, "t5_saw_addr5");
        rstn = 1'b0;
        #1;
        check_outputs_zero("t5_abort");
        repeat (3) step();
        check("t5_no_done", fd_cnt - b_fd, 0);
        check("t5_pixels_before_abort", de_cnt - b_de, 4);
        check("t5_pending", exp_q.size(), 8);
        exp_q.delete();
        rstn = 1'b1;
        repeat (2) step();
        snap(); push_frame(); pulse_start(s);
        wait_fd(b_fd + 1, "t5_done_seen");
        check("t5_frame_len", fd_cyc - s, FRAME_LEN);
        repeat (6) step();
        check_frame("t5", 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
